// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the RF module control path: controller FSM states,
// MCU mode pin codes and the fixed UART_mcu configuration used in sleep mode.
package rf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } mode_state_e;

    // {M1, M0} encodings
    localparam logic [1:0] MODE_NORMAL    = 2'b00;
    localparam logic [1:0] MODE_WAKEUP    = 2'b01;
    localparam logic [1:0] MODE_POWERSAVE = 2'b10;
    localparam logic [1:0] MODE_SLEEP     = 2'b11;

    // UART_mcu runs a fixed configuration while in sleep mode
    localparam logic [7:0] UART_MCU_MODE3_CONFIG = 8'b00100011;

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs. Each bit is
// synchronized independently; no multi-bit coherency is implied.
module bit_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; both stages clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mode_controller.sv
// Mode controller: synchronizes the MCU mode pins, waits for the datapath to
// drain, commits the new mode and UART_mcu config in a single SWITCH cycle,
// then holds AUX low for a settle period before accepting the next request.
module mode_controller
    import rf_ctrl_pkg::*;
#(
    parameter int SWITCH_DELAY_CLK  = 100,
    parameter int UART_CONFIG_WIDTH = 8,
    parameter logic [UART_CONFIG_WIDTH-1:0] UART_MCU_MODE3_CONFIG =
        UART_CONFIG_WIDTH'(rf_ctrl_pkg::UART_MCU_MODE3_CONFIG),
    parameter logic [UART_CONFIG_WIDTH-1:0] DEFAULT_CONFIG =
        UART_CONFIG_WIDTH'(8'b00100011)
) (
    input  logic                         internal_clk,
    input  logic                         rst,
    input  logic                         M0,
    input  logic                         M1,
    input  logic                         busy,
    input  logic                         cfg_load,
    input  logic [UART_CONFIG_WIDTH-1:0] cfg_in,
    output logic                         M0_sync,
    output logic                         M1_sync,
    output logic                         AUX,
    output logic [UART_CONFIG_WIDTH-1:0] uart_mcu_config_reg,
    output logic                         mode_change
);

    // Extra bit keeps the load value representable for any delay, incl. powers of two
    localparam int                CNT_W    = $clog2(SWITCH_DELAY_CLK) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SWITCH_DELAY_CLK - 1);

    mode_state_e                  state, state_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic [1:0]                   req_mode;
    logic [1:0]                   cur_mode;
    logic [UART_CONFIG_WIDTH-1:0] pending_cfg;
    logic [UART_CONFIG_WIDTH-1:0] active_cfg;
    logic                         aux_q;
    logic                         mode_change_q;

    bit_synchronizer #(
        .WIDTH (2)
    ) u_mode_sync (
        .clk (internal_clk),
        .rst (rst),
        .d   ({M1, M0}),
        .q   (req_mode)
    );

    // Next-state and settle counter; SETTLE ignores req_mode entirely
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (req_mode != cur_mode)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A request that reverts before the drain finishes is dropped
                if (req_mode == cur_mode)
                    state_nxt = ST_IDLE;
                else if (!busy)
                    state_nxt = ST_SWITCH;
            end
            ST_SWITCH: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = CNT_LOAD;
            end
            ST_SETTLE: begin
                if (cnt == '0)
                    state_nxt = ST_IDLE;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            default: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = CNT_LOAD;
            end
        endcase
    end

    // State register; AUX and mode_change are registered copies of the next state
    always_ff @(posedge internal_clk) begin
        if (rst) begin
            state         <= ST_SETTLE;
            cnt           <= CNT_LOAD;
            aux_q         <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            aux_q         <= (state_nxt == ST_IDLE);
            mode_change_q <= (state_nxt == ST_SWITCH);
        end
    end

    // Committed mode and config; only the SWITCH edge touches cur_mode/active_cfg
    always_ff @(posedge internal_clk) begin
        if (rst) begin
            cur_mode    <= MODE_NORMAL;
            pending_cfg <= DEFAULT_CONFIG;
            active_cfg  <= DEFAULT_CONFIG;
        end else begin
            if (cfg_load)
                pending_cfg <= cfg_in;
            if (state == ST_SWITCH) begin
                cur_mode   <= req_mode;
                // A load coinciding with the commit bypasses pending_cfg
                active_cfg <= cfg_load ? cfg_in : pending_cfg;
            end
        end
    end

    assign M0_sync             = cur_mode[0];
    assign M1_sync             = cur_mode[1];
    assign AUX                 = aux_q;
    assign mode_change         = mode_change_q;
    assign uart_mcu_config_reg = (cur_mode == MODE_SLEEP) ? UART_MCU_MODE3_CONFIG
                                                          : active_cfg;

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller with SWITCH_DELAY_CLK=4. The reset
// config is overridden so it differs from the sleep-mode config.
module tb_mode_controller;

    localparam logic [7:0] DEF_CFG = 8'h5C;
    localparam logic [7:0] M3_CFG  = 8'h23;

    logic       internal_clk = 1'b0;
    logic       rst = 1'b1;
    logic       M0 = 1'b0, M1 = 1'b0, busy = 1'b0, cfg_load = 1'b0;
    logic [7:0] cfg_in = 8'h00;
    logic       M0_sync, M1_sync, AUX, mode_change;
    logic [7:0] cfg;

    int tests = 0;
    int fails = 0;

    always #5 internal_clk = ~internal_clk;

    mode_controller #(
        .SWITCH_DELAY_CLK  (4),
        .UART_CONFIG_WIDTH (8),
        .DEFAULT_CONFIG    (DEF_CFG)
    ) dut (
        .internal_clk        (internal_clk),
        .rst                 (rst),
        .M0                  (M0),
        .M1                  (M1),
        .busy                (busy),
        .cfg_load            (cfg_load),
        .cfg_in              (cfg_in),
        .M0_sync             (M0_sync),
        .M1_sync             (M1_sync),
        .AUX                 (AUX),
        .uart_mcu_config_reg (cfg),
        .mode_change         (mode_change)
    );

    task automatic tick();
        @(posedge internal_clk);
        #1;
    endtask

    task automatic test_reset();
        int first_high = 0;
        int mc = 0;
        rst = 1'b1; M0 = 1'b0; M1 = 1'b0; busy = 1'b0; cfg_load = 1'b0;
        tick(); tick();
        tests++; if (AUX !== 1'b0) begin fails++; $display("FAIL reset_aux: got %0b expected 0", AUX); end
        tests++; if (mode_change !== 1'b0) begin fails++; $display("FAIL reset_mc: got %0b expected 0", mode_change); end
        tests++; if ({M1_sync, M0_sync} !== 2'b00) begin fails++; $display("FAIL reset_mode: got %0b expected 00", {M1_sync, M0_sync}); end
        tests++; if (cfg !== DEF_CFG) begin fails++; $display("FAIL reset_cfg: got %0h expected %0h", cfg, DEF_CFG); end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (AUX === 1'b1 && first_high == 0) first_high = i;
            if (mode_change === 1'b1) mc++;
        end
        tests++; if (first_high != 4) begin fails++; $display("FAIL reset_settle: aux high at %0d expected 4", first_high); end
        tests++; if (mc != 0) begin fails++; $display("FAIL reset_no_mc: got %0d pulses expected 0", mc); end
        tests++; if (cfg !== DEF_CFG) begin fails++; $display("FAIL reset_cfg_idle: got %0h expected %0h", cfg, DEF_CFG); end
    endtask

    task automatic test_switch_sleep();
        int low = 0, first_low = 0, mc = 0, mc_at = 0;
        M0 = 1'b1; M1 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (AUX === 1'b0) begin low++; if (first_low == 0) first_low = i; end
            if (mode_change === 1'b1) begin
                mc++; mc_at = i;
                tests++; if ({M1_sync, M0_sync} !== 2'b00) begin fails++; $display("FAIL sleep_uncommitted: got %0b expected 00", {M1_sync, M0_sync}); end
            end
        end
        tests++; if (first_low != 3) begin fails++; $display("FAIL sleep_latency: aux low at %0d expected 3", first_low); end
        tests++; if (low != 6) begin fails++; $display("FAIL sleep_aux_low: got %0d cycles expected 6", low); end
        tests++; if (mc != 1 || mc_at != 4) begin fails++; $display("FAIL sleep_mc: got %0d pulses at %0d expected 1 at 4", mc, mc_at); end
        tests++; if ({M1_sync, M0_sync} !== 2'b11) begin fails++; $display("FAIL sleep_mode: got %0b expected 11", {M1_sync, M0_sync}); end
        tests++; if (cfg !== M3_CFG) begin fails++; $display("FAIL sleep_cfg: got %0h expected %0h", cfg, M3_CFG); end
        tests++; if (AUX !== 1'b1) begin fails++; $display("FAIL sleep_aux_end: got %0b expected 1", AUX); end
    endtask

    task automatic test_cfg_load();
        int mc = 0, mc_at = 0;
        cfg_in = 8'h3A; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; cfg_in = 8'h00;
        tests++; if (cfg !== M3_CFG) begin fails++; $display("FAIL cfg_held: got %0h expected %0h", cfg, M3_CFG); end
        M0 = 1'b0; M1 = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (mode_change === 1'b1) begin
                mc++; mc_at = i;
                tests++; if (cfg !== M3_CFG) begin fails++; $display("FAIL cfg_before_commit: got %0h expected %0h", cfg, M3_CFG); end
            end
        end
        tests++; if (mc != 1 || mc_at != 4) begin fails++; $display("FAIL cfg_mc: got %0d pulses at %0d expected 1 at 4", mc, mc_at); end
        tests++; if (cfg !== 8'h3A) begin fails++; $display("FAIL cfg_applied: got %0h expected 3a", cfg); end
        tests++; if ({M1_sync, M0_sync} !== 2'b00) begin fails++; $display("FAIL cfg_mode: got %0b expected 00", {M1_sync, M0_sync}); end
    endtask

    task automatic test_drain_busy();
        busy = 1'b1; M0 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i >= 3) begin
                tests++; if (AUX !== 1'b0) begin fails++; $display("FAIL drain_aux[%0d]: got %0b expected 0", i, AUX); end
            end
            tests++; if ({M1_sync, M0_sync} !== 2'b00 || mode_change !== 1'b0) begin
                fails++; $display("FAIL drain_hold[%0d]: got mode %0b mc %0b expected 00/0", i, {M1_sync, M0_sync}, mode_change);
            end
        end
        busy = 1'b0;
        tick();
        tests++; if (mode_change !== 1'b1) begin fails++; $display("FAIL drain_switch: got mc %0b expected 1", mode_change); end
        tick();
        tests++; if ({M1_sync, M0_sync} !== 2'b01 || mode_change !== 1'b0) begin
            fails++; $display("FAIL drain_commit: got mode %0b mc %0b expected 01/0", {M1_sync, M0_sync}, mode_change);
        end
        tests++; if (cfg !== 8'h3A) begin fails++; $display("FAIL drain_cfg: got %0h expected 3a", cfg); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 3) begin
                tests++; if (AUX !== 1'b0) begin fails++; $display("FAIL drain_settle: got %0b expected 0", AUX); end
            end
        end
        tests++; if (AUX !== 1'b1) begin fails++; $display("FAIL drain_idle: got %0b expected 1", AUX); end
    endtask

    task automatic test_drain_abort();
        int mc = 0, first_high = 0;
        busy = 1'b1; M0 = 1'b0;
        tick(); tick(); tick();
        tests++; if (AUX !== 1'b0) begin fails++; $display("FAIL abort_drain: got %0b expected 0", AUX); end
        M0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (mode_change === 1'b1) mc++;
            if (AUX === 1'b1 && first_high == 0) first_high = i;
        end
        tests++; if (first_high != 3) begin fails++; $display("FAIL abort_idle: aux high at %0d expected 3", first_high); end
        tests++; if (mc != 0) begin fails++; $display("FAIL abort_no_mc: got %0d pulses expected 0", mc); end
        tests++; if ({M1_sync, M0_sync} !== 2'b01) begin fails++; $display("FAIL abort_mode: got %0b expected 01", {M1_sync, M0_sync}); end
        busy = 1'b0;
    endtask

    task automatic test_settle_ignore();
        int mc = 0, mc1 = 0, mc2 = 0;
        M0 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (mode_change === 1'b1) begin mc++; if (mc1 == 0) mc1 = i; else mc2 = i; end
            if (i == 5) begin M1 = 1'b1; M0 = 1'b0; end
            if (i == 9) begin
                tests++; if (AUX !== 1'b1 || {M1_sync, M0_sync} !== 2'b00) begin
                    fails++; $display("FAIL settle_idle_gap: got aux %0b mode %0b expected 1/00", AUX, {M1_sync, M0_sync});
                end
            end
            if (i == 10) begin
                tests++; if (AUX !== 1'b0) begin fails++; $display("FAIL settle_second_drain: got %0b expected 0", AUX); end
            end
        end
        tests++; if (mc != 2 || mc1 != 4 || mc2 != 11) begin
            fails++; $display("FAIL settle_mc: got %0d pulses at %0d,%0d expected 2 at 4,11", mc, mc1, mc2);
        end
        tests++; if ({M1_sync, M0_sync} !== 2'b10 || AUX !== 1'b1) begin
            fails++; $display("FAIL settle_final: got mode %0b aux %0b expected 10/1", {M1_sync, M0_sync}, AUX);
        end
    endtask

    task automatic test_reset_mid_settle();
        int first_high = 0, mc = 0;
        M1 = 1'b0; M0 = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        M1 = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        tests++; if ({M1_sync, M0_sync} !== 2'b10 || AUX !== 1'b0) begin
            fails++; $display("FAIL rst_pre: got mode %0b aux %0b expected 10/0", {M1_sync, M0_sync}, AUX);
        end
        rst = 1'b1; M1 = 1'b0;
        tick();
        rst = 1'b0;
        tests++; if ({M1_sync, M0_sync} !== 2'b00 || cfg !== DEF_CFG || AUX !== 1'b0 || mode_change !== 1'b0) begin
            fails++; $display("FAIL rst_mid: got mode %0b cfg %0h aux %0b mc %0b expected 00/%0h/0/0",
                              {M1_sync, M0_sync}, cfg, AUX, mode_change, DEF_CFG);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (AUX === 1'b1 && first_high == 0) first_high = i;
            if (mode_change === 1'b1) mc++;
        end
        tests++; if (first_high != 4 || mc != 0) begin
            fails++; $display("FAIL rst_settle: aux high at %0d mc %0d expected 4/0", first_high, mc);
        end
        // pending config must have been reset too, not still 3a
        M0 = 1'b1;
        for (int i = 1; i <= 14; i++) tick();
        tests++; if ({M1_sync, M0_sync} !== 2'b01 || cfg !== DEF_CFG) begin
            fails++; $display("FAIL rst_pending: got mode %0b cfg %0h expected 01/%0h", {M1_sync, M0_sync}, cfg, DEF_CFG);
        end
    endtask

    initial begin
        test_reset();
        test_switch_sleep();
        test_cfg_load();
        test_drain_busy();
        test_drain_abort();
        test_settle_ignore();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
